axi_mem_subordinate: RTL and testbench



---
 rtl/axi_mem_subordinate.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axi_mem_subordinate.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_subordinate.sv
// axi_mem_subordinate
//   Single-port AXI subordinate memory model. Terminates one manager's AXI
//   channels and backs them with a word-addressed array of 64-bit words.
//   Serves single-beat reads and writes with programmable response latency.
//   The write and read paths are independent FSMs.
//   Each path keeps at most one transaction outstanding.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   i_axi_s_aw / awvalid   write address in,  o_axi_s_awready accept
//   i_axi_s_w  / wvalid    write data in,     o_axi_s_wready  accept
//   o_axi_s_b  / bvalid    write response out, i_axi_s_bready accept
//   i_axi_s_ar / arvalid   read address in,   o_axi_s_arready accept
//   o_axi_s_r  / rvalid    read response out, i_axi_s_rready  accept
//
// Write FSM
//   state     | meaning
//   W_COLLECT | gathering AW and W in either order; readies high until each is held
//   W_LAT     | write committed, counting down response latency
//   W_RESP    | bvalid high, waiting for bready
// Read FSM
//   state     | meaning
//   R_IDLE    | arready high, waiting for AR
//   R_LAT     | response sampled, counting down read latency
//   R_RESP    | rvalid high, waiting for rready

package axi_pkg;
   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } axi_aw_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } axi_ar_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic              last;
   } axi_w_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [1:0]      resp;
   } axi_b_t;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic              last;
   } axi_r_t;
endpackage

module axi_mem_subordinate
   import axi_pkg::*;
#(
   parameter int MEM_DEPTH     = 1024,  // power of two
   parameter int READ_LATENCY  = 2,     // >= 1
   parameter int WRITE_LATENCY = 1      // >= 1
) (
   input  logic    clk,
   input  logic    rst,
   input  axi_aw_t i_axi_s_aw,
   output logic    o_axi_s_awready,
   input  logic    i_axi_s_awvalid,
   input  axi_w_t  i_axi_s_w,
   output logic    o_axi_s_wready,
   input  logic    i_axi_s_wvalid,
   output axi_b_t  o_axi_s_b,
   input  logic    i_axi_s_bready,
   output logic    o_axi_s_bvalid,
   input  axi_ar_t i_axi_s_ar,
   output logic    o_axi_s_arready,
   input  logic    i_axi_s_arvalid,
   output axi_r_t  o_axi_s_r,
   input  logic    i_axi_s_rready,
   output logic    o_axi_s_rvalid
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {W_COLLECT, W_LAT, W_RESP} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP} rstate_t;

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   wstate_t           wstate;
   logic              aw_got;
   logic              w_got;
   logic [ID_W-1:0]   aw_id_q;
   logic [IDX_W-1:0]  aw_idx_q;
   logic              aw_ok_q;
   logic [DATA_W-1:0] w_data_q;
   logic [STRB_W-1:0] w_strb_q;
   logic [CNT_W-1:0]  w_cnt;

   rstate_t           rstate;
   logic [CNT_W-1:0]  r_cnt;

   logic              aw_hs;
   logic              w_hs;
   logic              ar_hs;
   logic              commit;
   logic [ID_W-1:0]   cm_id;
   logic [IDX_W-1:0]  cm_idx;
   logic              cm_ok;
   logic [DATA_W-1:0] cm_data;
   logic [STRB_W-1:0] cm_strb;
   logic [IDX_W-1:0]  ar_idx;

   // Commit happens on the edge where the later of AW/W handshakes, so the
   // commit fields take the live channel when it is handshaking this cycle.
   always_comb begin
      aw_hs   = i_axi_s_awvalid & o_axi_s_awready;
      w_hs    = i_axi_s_wvalid & o_axi_s_wready;
      ar_hs   = i_axi_s_arvalid & o_axi_s_arready;
      commit  = (wstate == W_COLLECT) & (aw_got | aw_hs) & (w_got | w_hs);
      cm_id   = aw_hs ? i_axi_s_aw.id : aw_id_q;
      cm_idx  = aw_hs ? i_axi_s_aw.addr[3 +: IDX_W] : aw_idx_q;
      cm_ok   = aw_hs ? (i_axi_s_aw.len == 8'd0) : aw_ok_q;
      cm_data = w_hs ? i_axi_s_w.data : w_data_q;
      cm_strb = w_hs ? i_axi_s_w.strb : w_strb_q;
      ar_idx  = i_axi_s_ar.addr[3 +: IDX_W];
   end

   // Storage is never reset; a commit cannot occur while rst is high
   // because the readies and capture flags are held clear.
   always_ff @(posedge clk) begin
      if (commit && cm_ok) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (cm_strb[i]) begin
               mem[cm_idx][8*i +: 8] <= cm_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wstate          <= W_COLLECT;
         o_axi_s_awready <= 1'b0;
         o_axi_s_wready  <= 1'b0;
         o_axi_s_bvalid  <= 1'b0;
         o_axi_s_b       <= '0;
         aw_got          <= 1'b0;
         w_got           <= 1'b0;
         aw_id_q         <= '0;
         aw_idx_q        <= '0;
         aw_ok_q         <= 1'b0;
         w_data_q        <= '0;
         w_strb_q        <= '0;
         w_cnt           <= '0;
      end else begin
         case (wstate)
            W_COLLECT: begin
               if (aw_hs) begin
                  aw_id_q  <= i_axi_s_aw.id;
                  aw_idx_q <= i_axi_s_aw.addr[3 +: IDX_W];
                  aw_ok_q  <= (i_axi_s_aw.len == 8'd0);
               end
               if (w_hs) begin
                  w_data_q <= i_axi_s_w.data;
                  w_strb_q <= i_axi_s_w.strb;
               end
               if (commit) begin
                  aw_got          <= 1'b0;
                  w_got           <= 1'b0;
                  o_axi_s_awready <= 1'b0;
                  o_axi_s_wready  <= 1'b0;
                  o_axi_s_b.id    <= cm_id;
                  o_axi_s_b.resp  <= cm_ok ? RESP_OKAY : RESP_SLVERR;
                  w_cnt           <= CNT_W'(WRITE_LATENCY - 1);
                  wstate          <= W_LAT;
               end else begin
                  aw_got          <= aw_got | aw_hs;
                  w_got           <= w_got | w_hs;
                  o_axi_s_awready <= ~(aw_got | aw_hs);
                  o_axi_s_wready  <= ~(w_got | w_hs);
               end
            end
            W_LAT: begin
               if (w_cnt == '0) begin
                  o_axi_s_bvalid <= 1'b1;
                  wstate         <= W_RESP;
               end else begin
                  w_cnt <= w_cnt - 1'b1;
               end
            end
            W_RESP: begin
               if (i_axi_s_bready) begin
                  o_axi_s_bvalid  <= 1'b0;
                  o_axi_s_awready <= 1'b1;
                  o_axi_s_wready  <= 1'b1;
                  wstate          <= W_COLLECT;
               end
            end
            default: wstate <= W_COLLECT;
         endcase
      end
   end

   // The array word is sampled on the AR handshake edge, so a same-edge
   // write to that word is not yet visible and the old data is returned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rstate          <= R_IDLE;
         o_axi_s_arready <= 1'b0;
         o_axi_s_rvalid  <= 1'b0;
         o_axi_s_r       <= '0;
         r_cnt           <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (ar_hs) begin
                  o_axi_s_arready <= 1'b0;
                  o_axi_s_r.id    <= i_axi_s_ar.id;
                  o_axi_s_r.last  <= 1'b1;
                  if (i_axi_s_ar.len == 8'd0) begin
                     o_axi_s_r.data <= mem[ar_idx];
                     o_axi_s_r.resp <= RESP_OKAY;
                  end else begin
                     o_axi_s_r.data <= '0;
                     o_axi_s_r.resp <= RESP_SLVERR;
                  end
                  r_cnt  <= CNT_W'(READ_LATENCY - 1);
                  rstate <= R_LAT;
               end else begin
                  o_axi_s_arready <= 1'b1;
               end
            end
            R_LAT: begin
               if (r_cnt == '0) begin
                  o_axi_s_rvalid <= 1'b1;
                  rstate         <= R_RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            R_RESP: begin
               if (i_axi_s_rready) begin
                  o_axi_s_rvalid  <= 1'b0;
                  o_axi_s_arready <= 1'b1;
                  rstate          <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_mem_subordinate.sv
// tb_axi_mem_subordinate
//   Directed bench for axi_mem_subordinate with hand-computed expectations.
//   Inputs are driven and outputs sampled 1 ns after each rising edge.

module tb_axi_mem_subordinate;
   import axi_pkg::*;

   localparam int RL = 2;
   localparam int WL = 1;

   logic    clk;
   logic    rst;
   axi_aw_t aw;
   logic    awready;
   logic    awvalid;
   axi_w_t  w;
   logic    wready;
   logic    wvalid;
   axi_b_t  b;
   logic    bready;
   logic    bvalid;
   axi_ar_t ar;
   logic    arready;
   logic    arvalid;
   axi_r_t  r;
   logic    rready;
   logic    rvalid;

   int n_chk;
   int n_fail;

   axi_mem_subordinate #(
      .MEM_DEPTH    (1024),
      .READ_LATENCY (RL),
      .WRITE_LATENCY(WL)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_axi_s_aw     (aw),
      .o_axi_s_awready(awready),
      .i_axi_s_awvalid(awvalid),
      .i_axi_s_w      (w),
      .o_axi_s_wready (wready),
      .i_axi_s_wvalid (wvalid),
      .o_axi_s_b      (b),
      .i_axi_s_bready (bready),
      .o_axi_s_bvalid (bvalid),
      .i_axi_s_ar     (ar),
      .o_axi_s_arready(arready),
      .i_axi_s_arvalid(arvalid),
      .o_axi_s_r      (r),
      .i_axi_s_rready (rready),
      .o_axi_s_rvalid (rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_aw(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
      aw       = '0;
      aw.addr  = addr;
      aw.id    = id;
      aw.len   = len;
      aw.size  = 3'd3;
      aw.burst = 2'd1;
   endtask

   task automatic set_w(input logic [63:0] data, input logic [7:0] strb);
      w      = '0;
      w.data = data;
      w.strb = strb;
      w.last = 1'b1;
   endtask

   task automatic set_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
      ar       = '0;
      ar.addr  = addr;
      ar.id    = id;
      ar.len   = len;
      ar.size  = 3'd3;
      ar.burst = 2'd1;
   endtask

   // AW and W presented in the same cycle; B expected WL edges later.
   task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                           input logic [3:0] id, input logic [7:0] len, input logic [1:0] exp_resp);
      check_val("wr_awready_pre", 64'(awready), 64'd1);
      check_val("wr_wready_pre", 64'(wready), 64'd1);
      set_aw(addr, id, len);
      set_w(data, strb);
      awvalid = 1'b1;
      wvalid  = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check_val("wr_awready_drop", 64'(awready), 64'd0);
      check_val("wr_wready_drop", 64'(wready), 64'd0);
      check_val("wr_bvalid_early", 64'(bvalid), 64'd0);
      for (int i = 1; i < WL; i++) begin
         tick();
         check_val("wr_bvalid_lat", 64'(bvalid), 64'd0);
      end
      tick();
      check_val("wr_bvalid", 64'(bvalid), 64'd1);
      check_val("wr_bid", 64'(b.id), 64'(id));
      check_val("wr_bresp", 64'(b.resp), 64'(exp_resp));
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check_val("wr_bvalid_done", 64'(bvalid), 64'd0);
      check_val("wr_awready_back", 64'(awready), 64'd1);
      check_val("wr_wready_back", 64'(wready), 64'd1);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [63:0] exp_data, input logic [1:0] exp_resp);
      check_val("rd_arready_pre", 64'(arready), 64'd1);
      set_ar(addr, id, len);
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      check_val("rd_arready_drop", 64'(arready), 64'd0);
      check_val("rd_rvalid_early", 64'(rvalid), 64'd0);
      for (int i = 1; i < RL; i++) begin
         tick();
         check_val("rd_rvalid_lat", 64'(rvalid), 64'd0);
      end
      tick();
      check_val("rd_rvalid", 64'(rvalid), 64'd1);
      check_val("rd_data", r.data, exp_data);
      check_val("rd_id", 64'(r.id), 64'(id));
      check_val("rd_resp", 64'(r.resp), 64'(exp_resp));
      check_val("rd_last", 64'(r.last), 64'd1);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check_val("rd_rvalid_done", 64'(rvalid), 64'd0);
      check_val("rd_arready_back", 64'(arready), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rst     = 1'b1;
      aw      = '0;
      w       = '0;
      ar      = '0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      arvalid = 1'b0;
      bready  = 1'b0;
      rready  = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_awready", 64'(awready), 64'd0);
      check_val("rst_wready", 64'(wready), 64'd0);
      check_val("rst_arready", 64'(arready), 64'd0);
      check_val("rst_bvalid", 64'(bvalid), 64'd0);
      check_val("rst_rvalid", 64'(rvalid), 64'd0);
      check_val("rst_b", 64'(b), 64'd0);
      check_val("rst_rdata", r.data, 64'd0);
      rst = 1'b0;
      tick();
      check_val("rel_awready", 64'(awready), 64'd1);
      check_val("rel_wready", 64'(wready), 64'd1);
      check_val("rel_arready", 64'(arready), 64'd1);

      // basic write/read
      do_write(32'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF, 4'd3, 8'd0, RESP_OKAY);
      do_read(32'h40, 4'd3, 8'd0, 64'hDEADBEEF_CAFEF00D, RESP_OKAY);
      // aliasing: high address bits and addr[2:0] ignored
      do_read(32'h2045, 4'd6, 8'd0, 64'hDEADBEEF_CAFEF00D, RESP_OKAY);

      // AW ahead of W by 15 cycles
      set_aw(32'h88, 4'd5, 8'd0);
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         check_val("awfirst_awready", 64'(awready), 64'd0);
         check_val("awfirst_wready", 64'(wready), 64'd1);
         check_val("awfirst_bvalid", 64'(bvalid), 64'd0);
         if (i < 14) tick();
      end
      set_w(64'h1111, 8'hFF);
      wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      check_val("awfirst_wready_drop", 64'(wready), 64'd0);
      check_val("awfirst_bvalid_early", 64'(bvalid), 64'd0);
      tick();
      check_val("awfirst_bvalid", 64'(bvalid), 64'd1);
      check_val("awfirst_bid", 64'(b.id), 64'd5);
      check_val("awfirst_bresp", 64'(b.resp), 64'(RESP_OKAY));
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check_val("awfirst_bvalid_done", 64'(bvalid), 64'd0);
      do_read(32'h88, 4'd1, 8'd0, 64'h1111, RESP_OKAY);

      // strobes
      do_write(32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'd2, 8'd0, RESP_OKAY);
      do_write(32'h100, 64'h0, 8'h0F, 4'd2, 8'd0, RESP_OKAY);
      do_read(32'h100, 4'd2, 8'd0, 64'hFFFF_FFFF_0000_0000, RESP_OKAY);

      // write backpressure: bready low 5 cycles with new AW/W pending
      set_aw(32'h200, 4'd8, 8'd0);
      set_w(64'h0123_4567_89AB_CDEF, 8'hFF);
      awvalid = 1'b1;
      wvalid  = 1'b1;
      tick();
      set_aw(32'h208, 4'd9, 8'd0);
      set_w(64'h5555, 8'hFF);
      tick();
      for (int i = 0; i < 5; i++) begin
         check_val("bp_bvalid", 64'(bvalid), 64'd1);
         check_val("bp_b", 64'(b), 64'({4'd8, RESP_OKAY}));
         check_val("bp_awready", 64'(awready), 64'd0);
         check_val("bp_wready", 64'(wready), 64'd0);
         tick();
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b1;
      tick();
      bready = 1'b0;
      check_val("bp_bvalid_done", 64'(bvalid), 64'd0);
      check_val("bp_awready_back", 64'(awready), 64'd1);

      // read backpressure: rready low 5 cycles with a new AR pending
      set_ar(32'h200, 4'd10, 8'd0);
      arvalid = 1'b1;
      tick();
      set_ar(32'h208, 4'd11, 8'd0);
      repeat (RL) tick();
      for (int i = 0; i < 5; i++) begin
         check_val("bp_rvalid", 64'(rvalid), 64'd1);
         check_val("bp_rdata", r.data, 64'h0123_4567_89AB_CDEF);
         check_val("bp_rid", 64'(r.id), 64'd10);
         check_val("bp_arready", 64'(arready), 64'd0);
         tick();
      end
      arvalid = 1'b0;
      rready  = 1'b1;
      tick();
      rready = 1'b0;
      check_val("bp_rvalid_done", 64'(rvalid), 64'd0);
      check_val("bp_arready_back", 64'(arready), 64'd1);
      // the held AW/W at 0x208 was never accepted
      do_read(32'h200, 4'd4, 8'd0, 64'h0123_4567_89AB_CDEF, RESP_OKAY);

      // collision: AR and write commit on the same edge to 0x10
      do_write(32'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 4'd1, 8'd0, RESP_OKAY);
      set_aw(32'h10, 4'd1, 8'd0);
      set_w(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF);
      set_ar(32'h10, 4'd2, 8'd0);
      awvalid = 1'b1;
      wvalid  = 1'b1;
      arvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      arvalid = 1'b0;
      tick();
      check_val("col_bvalid", 64'(bvalid), 64'd1);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check_val("col_rvalid", 64'(rvalid), 64'd1);
      check_val("col_rdata_old", r.data, 64'hAAAA_AAAA_AAAA_AAAA);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check_val("col_rvalid_done", 64'(rvalid), 64'd0);
      do_read(32'h10, 4'd2, 8'd0, 64'hBBBB_BBBB_BBBB_BBBB, RESP_OKAY);

      // error responses
      do_read(32'h40, 4'd7, 8'd1, 64'd0, RESP_SLVERR);
      do_write(32'h40, 64'h1234, 8'hFF, 4'd12, 8'd3, RESP_SLVERR);
      do_read(32'h40, 4'd7, 8'd0, 64'hDEADBEEF_CAFEF00D, RESP_OKAY);

      // reset mid-transaction: read in R_LAT, write with AW only captured
      set_ar(32'h40, 4'd4, 8'd0);
      set_aw(32'h300, 4'd6, 8'd0);
      arvalid = 1'b1;
      awvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      awvalid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_val("mid_awready", 64'(awready), 64'd0);
      check_val("mid_wready", 64'(wready), 64'd0);
      check_val("mid_arready", 64'(arready), 64'd0);
      check_val("mid_bvalid", 64'(bvalid), 64'd0);
      check_val("mid_rvalid", 64'(rvalid), 64'd0);
      check_val("mid_b", 64'(b), 64'd0);
      check_val("mid_rdata", r.data, 64'd0);
      check_val("mid_rmeta", 64'({r.id, r.resp, r.last}), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check_val("mid_rel_awready", 64'(awready), 64'd1);
      check_val("mid_rel_wready", 64'(wready), 64'd1);
      check_val("mid_rel_arready", 64'(arready), 64'd1);
      // a lone W must not pair with the dropped AW
      set_w(64'h9999, 8'hFF);
      wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check_val("mid_no_bvalid", 64'(bvalid), 64'd0);
         check_val("mid_no_rvalid", 64'(rvalid), 64'd0);
         check_val("mid_awready_wait", 64'(awready), 64'd1);
         tick();
      end
      set_aw(32'h300, 4'd6, 8'd0);
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      check_val("mid_late_bvalid", 64'(bvalid), 64'd1);
      check_val("mid_late_bid", 64'(b.id), 64'd6);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      do_read(32'h40, 4'd4, 8'd0, 64'hDEADBEEF_CAFEF00D, RESP_OKAY);
      do_read(32'h88, 4'd5, 8'd0, 64'h1111, RESP_OKAY);
      do_read(32'h300, 4'd6, 8'd0, 64'h9999, RESP_OKAY);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
